cache_mem_arbiter: RTL

Shares the single-ported RAM between the instruction cache and the data cache. Requests from both caches are arbitrated through a registered grant FSM. The data cache keeps its grant across a multi-word block burst (writeback or fill). A starvation counter bounds how long instruction fetch can wait. The block sits between the cache pair and the RAM controller and replaces direct cache-to-RAM wiring.

---
 rtl/cache_mem_arbiter.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/cache_mem_arbiter.sv
// ---------------------------------------------------------------------------
// cache_mem_arbiter
//
// Shares one single-ported RAM between the instruction cache and the data
// cache. A registered grant FSM picks one requester at a time:
//   * the dcache keeps its grant across a BURST_LEN-word block burst,
//   * a starvation counter makes a long-waiting icache win arbitration,
//   * a release from one cache hands the RAM to the other if it is waiting.
//
// Handshake (both caches): a cache raises its request (iREN, or dREN/dWEN)
// and holds it, with address/data stable, until it sees its wait output low.
// wait low marks the single cycle in which the access completes and the load
// data (iload/dload, a passthrough of ramload) is valid. A cache may drop its
// request early to abandon it. No other cycle is a transfer.
//
// Ports
//   CLK, nRST              clock, asynchronous active-low reset
//   iREN, iaddr            icache read request and word address
//   iwait, iload           icache stall and read data
//   dREN, dWEN, daddr,     dcache read/write request, word address,
//   dstore                 write data
//   dwait, dload           dcache stall and read data
//   ramREN, ramWEN,        RAM controller request side
//   ramaddr, ramstore
//   ramload, ramstate      RAM read data and status (FREE/BUSY/ACCESS/ERROR)
//   gnt                    current grant (0 none, 1 icache, 2 dcache); this
//                          is the FSM state register itself
//   ram_err                sticky, set when ERROR is seen during a grant
// ---------------------------------------------------------------------------
module cache_mem_arbiter #(
  parameter int BURST_LEN  = 2,
  parameter int STARVE_MAX = 8,
  parameter int ADDR_W     = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [31:0]       iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [31:0]       dstore,
  output logic              dwait,
  output logic [31:0]       dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [31:0]       ramstore,
  input  logic [31:0]       ramload,
  input  logic [1:0]        ramstate,
  output logic [1:0]        gnt,
  output logic              ram_err
);

  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;

  localparam int BEAT_W   = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int STARVE_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
  } state_t;

  state_t              state;
  state_t              next_state;
  logic [BEAT_W-1:0]   beat_cnt;
  logic [BEAT_W-1:0]   next_beat_cnt;
  logic [STARVE_W-1:0] starve_cnt;
  logic [STARVE_W-1:0] next_starve_cnt;

  logic ireq;
  logic dreq;
  logic access;
  logic last_beat;
  logic starved;

  assign ireq      = iREN;
  assign dreq      = dREN | dWEN;
  assign access    = (ramstate == RS_ACCESS);
  assign last_beat = (beat_cnt == BEAT_W'(BURST_LEN - 1));
  assign starved   = (starve_cnt >= STARVE_W'(STARVE_MAX));

  // Read data is a plain passthrough; it only means something to the
  // requester whose wait is low.
  assign iload = ramload;
  assign dload = ramload;
  assign gnt   = state;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      beat_cnt   <= '0;
      starve_cnt <= '0;
      ram_err    <= 1'b0;
    end else begin
      state      <= next_state;
      beat_cnt   <= next_beat_cnt;
      starve_cnt <= next_starve_cnt;
      if ((state != IDLE) && (ramstate == RS_ERROR)) begin
        ram_err <= 1'b1;
      end
    end
  end

  // Grant FSM: next state, beat counter and all RAM/cache-side outputs.
  always_comb begin
    next_state    = state;
    next_beat_cnt = beat_cnt;
    ramREN        = 1'b0;
    ramWEN        = 1'b0;
    ramaddr       = '0;
    ramstore      = '0;
    iwait         = 1'b1;
    dwait         = 1'b1;

    case (state)
      IDLE: begin
        if (ireq && starved) begin
          next_state = IGNT;
        end else if (dreq) begin
          next_state = DGNT;
        end else if (ireq) begin
          next_state = IGNT;
        end
      end

      IGNT: begin
        // Gated by iREN so an abandoned fetch never starts a RAM read.
        ramREN  = iREN;
        ramaddr = iaddr;
        iwait   = !(access && iREN);
        if (!ireq) begin
          next_state = dreq ? DGNT : IDLE;
        end else if (access) begin
          // Hand over to the dcache if it is waiting, otherwise keep fetching.
          next_state = dreq ? DGNT : IGNT;
        end
      end

      DGNT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        dwait    = !(access && dreq);
        if (!dreq) begin
          // Abandoned burst: forget partial beats and release now.
          next_beat_cnt = '0;
          next_state    = ireq ? IGNT : IDLE;
        end else if (access) begin
          if (last_beat) begin
            next_beat_cnt = '0;
            next_state    = ireq ? IGNT : IDLE;
          end else begin
            next_beat_cnt = beat_cnt + BEAT_W'(1);
          end
        end
      end

      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Starvation counter: counts cycles a fetch is pending without the grant,
  // holds while the icache is granted but not yet served.
  always_comb begin
    next_starve_cnt = starve_cnt;
    if (!ireq) begin
      next_starve_cnt = '0;
    end else if (state == IGNT) begin
      if (access) begin
        next_starve_cnt = '0;
      end
    end else if (!starved) begin
      next_starve_cnt = starve_cnt + STARVE_W'(1);
    end
  end

endmodule
